hazard_unit: RTL and testbench

- Pipeline hazard detector for the pipelined LEGLite core, sitting in the ID stage.
- Tracks the destination registers of in-flight instructions in a small internal scoreboard.
- Produces the nop input consumed by the Control decoder, plus stall (hold PC and IF/ID) and flush (squash on a taken CBZ).
- Keeps saturating stall and flush counters for performance measurement.

---
 rtl/hazard_unit.sv | 160 ++++++++++++++++
 tb/tb_hazard_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// ID-stage hazard detector for the pipelined LEGLite core: tracks in-flight
// destination registers and produces nop/stall/flush plus saturating event counters.
module hazard_unit #(
  parameter int unsigned FORWARDING = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [2:0]       id_opcode,
  input  logic [2:0]       id_rn,
  input  logic [2:0]       id_rm,
  input  logic [2:0]       id_rd,
  input  logic             br_taken,
  output logic             nop,
  output logic             stall,
  output logic             flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_LD   = 3'd3;
  localparam logic [2:0] OP_ST   = 3'd4;
  localparam logic [2:0] OP_CBZ  = 3'd5;
  localparam logic [2:0] OP_ADDI = 3'd6;
  localparam logic [2:0] OP_ANDI = 3'd7;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic       use_rn_s, use_rm_s, use_rd_s;
  logic       dec_wr_s, dec_ld_s;
  logic       hazard_s;
  logic       nop_s, stall_s, flush_s;
  logic       ex_wr_r, ex_ld_r, mem_wr_r;
  logic [2:0] ex_dst_r, mem_dst_r;
  logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;

  // Without forwarding any writer still in EX or MEM blocks a reader;
  // with forwarding only a load sitting in EX does.
  function automatic logic src_hit(input logic [2:0] src);
    logic ex_hit, mem_hit;
    ex_hit  = ex_wr_r && (ex_dst_r == src);
    mem_hit = mem_wr_r && (mem_dst_r == src);
    if (FORWARDING != 32'd0) begin
      return ex_hit && ex_ld_r;
    end else begin
      return ex_hit || mem_hit;
    end
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  // Decode which register fields the ID instruction reads and whether it writes.
  always_comb begin
    use_rn_s = 1'b0;
    use_rm_s = 1'b0;
    use_rd_s = 1'b0;
    dec_wr_s = 1'b0;
    dec_ld_s = 1'b0;
    if (id_valid) begin
      case (id_opcode)
        OP_ADD, OP_SUB: begin
          use_rn_s = 1'b1;
          use_rm_s = 1'b1;
          dec_wr_s = 1'b1;
        end
        OP_LD: begin
          use_rn_s = 1'b1;
          dec_wr_s = 1'b1;
          dec_ld_s = 1'b1;
        end
        OP_ST: begin
          use_rn_s = 1'b1;
          use_rd_s = 1'b1;
        end
        OP_CBZ: begin
          use_rd_s = 1'b1;
        end
        OP_ADDI, OP_ANDI: begin
          use_rn_s = 1'b1;
          dec_wr_s = 1'b1;
        end
        default: begin
          use_rn_s = 1'b0;
        end
      endcase
    end else begin
      use_rn_s = 1'b0;
    end
  end

  // Hazard detection and output priority: reset, then flush, then stall.
  always_comb begin
    hazard_s = (use_rn_s && src_hit(id_rn)) ||
               (use_rm_s && src_hit(id_rm)) ||
               (use_rd_s && src_hit(id_rd));
    nop_s    = 1'b0;
    stall_s  = 1'b0;
    flush_s  = 1'b0;
    if (!reset) begin
      nop_s = 1'b1;
    end else if (br_taken) begin
      nop_s   = 1'b1;
      flush_s = 1'b1;
    end else if (hazard_s) begin
      nop_s   = 1'b1;
      stall_s = 1'b1;
    end else begin
      nop_s = 1'b0;
    end
  end

  assign nop       = nop_s;
  assign stall     = stall_s;
  assign flush     = flush_s;
  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;

  // Scoreboard advance: EX moves to MEM unless squashed, ID enters EX unless bubbled.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ex_wr_r   <= 1'b0;
      ex_ld_r   <= 1'b0;
      ex_dst_r  <= 3'd0;
      mem_wr_r  <= 1'b0;
      mem_dst_r <= 3'd0;
    end else begin
      mem_wr_r  <= br_taken ? 1'b0 : ex_wr_r;
      mem_dst_r <= br_taken ? 3'd0 : ex_dst_r;
      ex_wr_r   <= nop_s ? 1'b0 : dec_wr_s;
      ex_ld_r   <= nop_s ? 1'b0 : dec_ld_s;
      ex_dst_r  <= nop_s ? 3'd0 : id_rd;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (stall_s) begin
        stall_cnt_r <= sat_inc(stall_cnt_r);
      end
      if (flush_s) begin
        flush_cnt_r <= sat_inc(flush_cnt_r);
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: three configurations share one stimulus stream and
// are checked against a timing model built from instruction issue cycles.
module tb_hazard_unit;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic id_valid = 1'b0;
  logic [2:0] id_opcode = 3'd2, id_rn = 3'd0, id_rm = 3'd0, id_rd = 3'd0;
  logic br_taken = 1'b0;

  logic nop0, stall0, flush0, nop1, stall1, flush1, nop2, stall2, flush2;
  logic [15:0] scnt0, fcnt0, scnt1, fcnt1;
  logic [3:0]  scnt2, fcnt2;

  always #5 clock = ~clock;

  hazard_unit #(.FORWARDING(0), .CNT_W(16)) u_f0 (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd), .br_taken(br_taken),
    .nop(nop0), .stall(stall0), .flush(flush0), .stall_cnt(scnt0), .flush_cnt(fcnt0));
  hazard_unit #(.FORWARDING(1), .CNT_W(16)) u_f1 (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd), .br_taken(br_taken),
    .nop(nop1), .stall(stall1), .flush(flush1), .stall_cnt(scnt1), .flush_cnt(fcnt1));
  hazard_unit #(.FORWARDING(0), .CNT_W(4)) u_sat (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd), .br_taken(br_taken),
    .nop(nop2), .stall(stall2), .flush(flush2), .stall_cnt(scnt2), .flush_cnt(fcnt2));

  typedef struct packed {
    logic [1:0]  k;
    logic        nop, stall, flush;
    logic [31:0] scnt, fcnt;
  } exp_t;

  typedef struct packed {
    logic [1:0]  k;
    logic [31:0] cyc;
    logic [2:0]  dst;
    logic        ld;
  } flight_t;

  exp_t    exp_q[$];
  flight_t inflight[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int scnt_m[3] = '{0, 0, 0};
  int fcnt_m[3] = '{0, 0, 0};
  int cnt_max[3] = '{65535, 65535, 15};
  int fwd[3] = '{0, 1, 0};

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t got %0d expected %0d", name, k, $time, act, exp);
    end
  endtask

  // One instance's view of the cycle: hazard is decided by how many cycles ago a writer issued.
  task automatic model_step(input int k);
    bit urn, urm, urd, wr, ld, hz, hit;
    int age;
    exp_t e;
    flight_t keep[$];
    flight_t f;
    urn = 0; urm = 0; urd = 0; wr = 0; ld = 0; hz = 0;
    if (id_valid) begin
      case (id_opcode)
        3'd0, 3'd1: begin urn = 1; urm = 1; wr = 1; end
        3'd3:       begin urn = 1; wr = 1; ld = 1; end
        3'd4:       begin urn = 1; urd = 1; end
        3'd5:       begin urd = 1; end
        3'd6, 3'd7: begin urn = 1; wr = 1; end
        default:    begin end
      endcase
    end
    foreach (inflight[i]) begin
      if (inflight[i].k == k[1:0]) begin
        age = cyc - int'(inflight[i].cyc);
        hit = (urn && inflight[i].dst == id_rn) || (urm && inflight[i].dst == id_rm) ||
              (urd && inflight[i].dst == id_rd);
        if (hit && fwd[k] == 0 && (age == 1 || age == 2)) hz = 1;
        if (hit && fwd[k] == 1 && age == 1 && inflight[i].ld) hz = 1;
      end
    end
    e.k = k[1:0]; e.scnt = scnt_m[k]; e.fcnt = fcnt_m[k];
    e.nop = 1'b0; e.stall = 1'b0; e.flush = 1'b0;
    foreach (inflight[i]) begin
      age = cyc - int'(inflight[i].cyc);
      if (inflight[i].k != k[1:0]) keep.push_back(inflight[i]);
      else if (reset && !(br_taken && age == 1) && age < 3) keep.push_back(inflight[i]);
    end
    if (!reset) begin
      e.nop = 1'b1;
      scnt_m[k] = 0; fcnt_m[k] = 0;
    end else if (br_taken) begin
      e.nop = 1'b1; e.flush = 1'b1;
      if (fcnt_m[k] < cnt_max[k]) fcnt_m[k]++;
    end else if (hz) begin
      e.nop = 1'b1; e.stall = 1'b1;
      if (scnt_m[k] < cnt_max[k]) scnt_m[k]++;
    end else if (wr) begin
      f.k = k[1:0]; f.cyc = cyc; f.dst = id_rd; f.ld = ld;
      keep.push_back(f);
    end
    inflight = keep;
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit rst, input bit v, input logic [2:0] op, input logic [2:0] rn,
                       input logic [2:0] rm, input logic [2:0] rd, input bit br);
    @(posedge clock); #1;
    reset = rst; id_valid = v; id_opcode = op; id_rn = rn; id_rm = rm; id_rd = rd; br_taken = br;
    for (int k = 0; k < 3; k++) model_step(k);
    cyc++;
  endtask

  task automatic idle();
    drive(1, 0, 3'd2, 3'd0, 3'd0, 3'd0, 0);
  endtask

  // Monitor: every cycle the DUTs present outputs, compare against the oldest expectations.
  initial begin
    exp_t e;
    logic [31:0] a_nop, a_stall, a_flush, a_scnt, a_fcnt;
    forever begin
      @(negedge clock);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        case (e.k)
          2'd0: begin a_nop = 32'(nop0); a_stall = 32'(stall0); a_flush = 32'(flush0);
                      a_scnt = 32'(scnt0); a_fcnt = 32'(fcnt0); end
          2'd1: begin a_nop = 32'(nop1); a_stall = 32'(stall1); a_flush = 32'(flush1);
                      a_scnt = 32'(scnt1); a_fcnt = 32'(fcnt1); end
          default: begin a_nop = 32'(nop2); a_stall = 32'(stall2); a_flush = 32'(flush2);
                      a_scnt = 32'(scnt2); a_fcnt = 32'(fcnt2); end
        endcase
        check("nop", int'(e.k), a_nop, 32'(e.nop));
        check("stall", int'(e.k), a_stall, 32'(e.stall));
        check("flush", int'(e.k), a_flush, 32'(e.flush));
        check("stall_cnt", int'(e.k), a_scnt, e.scnt);
        check("flush_cnt", int'(e.k), a_fcnt, e.fcnt);
      end
    end
  end

  initial begin
    drive(0, 1, 3'd0, 3'd1, 3'd2, 3'd3, 1);
    drive(0, 0, 3'd2, 3'd0, 3'd0, 3'd0, 0);
    // ADD X1,X2,X3 then SUB X4,X1,X5 held in IF/ID until it issues
    drive(1, 1, 3'd0, 3'd2, 3'd3, 3'd1, 0);
    repeat (3) drive(1, 1, 3'd1, 3'd1, 3'd5, 3'd4, 0);
    @(negedge clock); #1;
    check("sub_issues_cycle3", 0, 32'(stall0), 32'd0);
    check("stall_cnt_after_add_sub", 0, 32'(scnt0), 32'd2);
    // load-use with a taken branch in the same cycle
    idle();
    drive(1, 1, 3'd3, 3'd0, 3'd0, 3'd2, 0);
    drive(1, 1, 3'd0, 3'd2, 3'd2, 3'd3, 1);
    idle();
    @(negedge clock); #1;
    check("flush_cnt_after_branch", 0, 32'(fcnt0), 32'd1);
    check("stall_cnt_unchanged", 0, 32'(scnt0), 32'd2);
    // load-use, then ADDI-use
    drive(1, 1, 3'd3, 3'd0, 3'd0, 3'd2, 0);
    repeat (3) drive(1, 1, 3'd0, 3'd2, 3'd2, 3'd3, 0);
    drive(1, 1, 3'd6, 3'd0, 3'd0, 3'd2, 0);
    repeat (3) drive(1, 1, 3'd0, 3'd2, 3'd2, 3'd3, 0);
    // ST reading rd after ADDI X1, then after a writer of X6
    drive(1, 1, 3'd6, 3'd1, 3'd0, 3'd1, 0);
    repeat (3) drive(1, 1, 3'd4, 3'd2, 3'd0, 3'd1, 0);
    repeat (2) idle();
    drive(1, 1, 3'd6, 3'd1, 3'd0, 3'd6, 0);
    drive(1, 1, 3'd4, 3'd2, 3'd0, 3'd1, 0);
    // reset in the middle of a stall, then an ADD X1 right after release
    drive(1, 1, 3'd0, 3'd2, 3'd3, 3'd1, 0);
    drive(1, 1, 3'd1, 3'd1, 3'd5, 3'd4, 0);
    drive(0, 1, 3'd1, 3'd1, 3'd5, 3'd4, 0);
    drive(0, 1, 3'd1, 3'd1, 3'd5, 3'd4, 1);
    drive(1, 1, 3'd0, 3'd1, 3'd1, 3'd1, 0);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(49) != 0), ($urandom_range(7) != 0), 3'($urandom_range(7)),
            3'($urandom_range(7)), 3'($urandom_range(7)), 3'($urandom_range(7)),
            ($urandom_range(7) == 0));
    end
    // saturation of the 4-bit counters
    drive(0, 0, 3'd2, 3'd0, 3'd0, 3'd0, 0);
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 3'd0, 3'd2, 3'd3, 3'd1, 0);
      repeat (3) drive(1, 1, 3'd1, 3'd1, 3'd5, 3'd4, 0);
    end
    idle();
    @(negedge clock); #1;
    check("stall_cnt_saturated", 2, 32'(scnt2), 32'd15);
    repeat (20) drive(1, 1, 3'd0, 3'd1, 3'd2, 3'd3, 1);
    idle();
    @(negedge clock); #1;
    check("flush_cnt_saturated", 2, 32'(fcnt2), 32'd15);
    repeat (4) @(posedge clock);
    if (exp_q.size() != 0) check("scoreboard_drained", 0, 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
